// File: rtl/afu_io_pkg.sv
// Shared types and helpers for the host-side streaming controller.
package afu_io_pkg;

  localparam int unsigned LINE_W = 512;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } io_state_e;

  // Lines allowed between read issue and write issue: one less than the FIFO depth.
  function automatic logic [CNT_W-1:0] inflight_limit(input int unsigned depth_bits);
    return CNT_W'((64'd1 << depth_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/afu_io_counter.sv
// Loadable job counter with increment enable and equals-length compare.
module afu_io_counter
  import afu_io_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] count,
  output logic             eq_c
);

  // Load has priority over increment so a new job always starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign eq_c = (count == len);

endmodule

// File: rtl/afu_io_ctrl.sv
// Host-side streaming controller: reads lines into the FFT input FIFO and
// writes transformed lines back, bounding lines in flight through the FFT.
module afu_io_ctrl
  import afu_io_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BUFF_DEPTH_BITS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      src_addr,
  input  logic [ADDR_WIDTH-1:0]      dst_addr,
  input  logic [31:0]                ctx_length,
  output logic                       rd_req_valid,
  output logic [ADDR_WIDTH-1:0]      rd_req_addr,
  input  logic                       rd_req_almostfull,
  input  logic                       rd_rsp_valid,
  input  logic [LINE_W-1:0]          rd_rsp_data,
  output logic                       wr_req_valid,
  output logic [ADDR_WIDTH-1:0]      wr_req_addr,
  output logic [LINE_W-1:0]          wr_req_data,
  input  logic                       wr_req_almostfull,
  input  logic                       wr_rsp_valid,
  output logic [LINE_W-1:0]          input_fifo_din,
  output logic                       input_fifo_we,
  input  logic                       input_fifo_almost_full,
  input  logic [BUFF_DEPTH_BITS-1:0] input_fifo_count,
  input  logic [LINE_W-1:0]          output_fifo_dout,
  output logic                       output_fifo_re,
  input  logic                       output_fifo_empty,
  input  logic                       output_fifo_almost_empty,
  output logic                       busy,
  output logic                       done
);

  localparam logic [CNT_W-1:0] INFLIGHT_MAX = inflight_limit(BUFF_DEPTH_BITS);

  io_state_e             state, state_nx;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [CNT_W-1:0]      len_q;
  logic [CNT_W-1:0]      rd_issued, wr_issued, wr_done, inflight;
  logic                  rd_eq, wr_eq, done_eq;
  logic                  accept_c, active_c, rd_issue_c, re_c, rsp_cnt_c, done_last_c, finish_c;
  logic                  wr_valid_q, in_we_q;
  logic [LINE_W-1:0]     in_din_q;
  logic                  monitor_unused;

  // FIFO fill-level inputs are observation-only; the inflight limit guarantees space.
  assign monitor_unused = ^{input_fifo_almost_full, input_fifo_count, output_fifo_almost_empty};

  assign accept_c    = start && ((state == IDLE) || (state == DONE));
  assign active_c    = (state == RUN) || (state == DRAIN);
  assign inflight    = rd_issued - wr_issued;
  // Counters never pass len, so "not equal" is the same as "less than".
  assign rd_issue_c  = (state == RUN) && !rd_eq && !rd_req_almostfull && (inflight < INFLIGHT_MAX);
  assign re_c        = (state == RUN) && !output_fifo_empty && !wr_req_almostfull && !wr_eq;
  assign rsp_cnt_c   = wr_rsp_valid && active_c;
  assign done_last_c = rsp_cnt_c && ((wr_done + CNT_W'(1)) == len_q);
  // The final response completes the job this cycle so done rises one cycle later.
  assign finish_c    = done_eq || done_last_c;

  afu_io_counter u_rd_cnt (
    .clk(clk), .rst_n(reset), .load(accept_c), .load_val('0),
    .inc(rd_issue_c), .len(len_q), .count(rd_issued), .eq_c(rd_eq)
  );

  afu_io_counter u_wr_cnt (
    .clk(clk), .rst_n(reset), .load(accept_c), .load_val('0),
    .inc(wr_valid_q), .len(len_q), .count(wr_issued), .eq_c(wr_eq)
  );

  afu_io_counter u_done_cnt (
    .clk(clk), .rst_n(reset), .load(accept_c), .load_val('0),
    .inc(rsp_cnt_c), .len(len_q), .count(wr_done), .eq_c(done_eq)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (ctx_length == '0) ? DONE : RUN;
      RUN:        if (wr_eq) state_nx = finish_c ? DONE : DRAIN;
      DRAIN:      if (finish_c) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Job parameters captured on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (accept_c) begin
      src_q <= src_addr;
      dst_q <= dst_addr;
      len_q <= ctx_length;
    end
  end

  // Response forwarding into the input FIFO and synchronous-read write staging.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_we_q    <= 1'b0;
      in_din_q   <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      in_we_q    <= rd_rsp_valid;
      in_din_q   <= rd_rsp_data;
      wr_valid_q <= re_c;
    end
  end

  assign rd_req_valid   = rd_issue_c;
  assign rd_req_addr    = rd_issue_c ? (src_q + ADDR_WIDTH'(rd_issued)) : '0;
  assign wr_req_valid   = wr_valid_q;
  assign wr_req_addr    = wr_valid_q ? (dst_q + ADDR_WIDTH'(wr_issued)) : '0;
  assign wr_req_data    = wr_valid_q ? output_fifo_dout : '0;
  assign input_fifo_we  = in_we_q;
  assign input_fifo_din = in_din_q;
  assign output_fifo_re = re_c;
  assign busy           = active_c;
  assign done           = (state == DONE);

endmodule

// File: tb/tb_afu_io_ctrl.sv
// Directed bench for afu_io_ctrl with host memory and FFT loopback models.
module tb_afu_io_ctrl;

  logic         clk, reset, start;
  logic [31:0]  src_addr, dst_addr, ctx_length;
  logic         rd_req_valid, rd_req_almostfull, rd_rsp_valid;
  logic [31:0]  rd_req_addr;
  logic [511:0] rd_rsp_data;
  logic         wr_req_valid, wr_req_almostfull, wr_rsp_valid;
  logic [31:0]  wr_req_addr;
  logic [511:0] wr_req_data;
  logic [511:0] input_fifo_din, output_fifo_dout;
  logic         input_fifo_we, input_fifo_almost_full;
  logic [2:0]   input_fifo_count;
  logic         output_fifo_re, output_fifo_empty, output_fifo_almost_empty;
  logic         busy, done;
  logic         fft_stall;

  afu_io_ctrl #(.ADDR_WIDTH(32), .BUFF_DEPTH_BITS(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .ctx_length(ctx_length),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_almostfull(wr_req_almostfull), .wr_rsp_valid(wr_rsp_valid),
    .input_fifo_din(input_fifo_din), .input_fifo_we(input_fifo_we),
    .input_fifo_almost_full(input_fifo_almost_full), .input_fifo_count(input_fifo_count),
    .output_fifo_dout(output_fifo_dout), .output_fifo_re(output_fifo_re),
    .output_fifo_empty(output_fifo_empty), .output_fifo_almost_empty(output_fifo_almost_empty),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] mk(input logic [31:0] a);
    return {16{a ^ 32'h5a5a_0000}};
  endfunction

  // Host memory, FFT loopback (bitwise invert) and write-completion models.
  logic [31:0]  rdq_addr[$];
  int           rdq_due[$];
  int           wrq_due[$];
  logic [511:0] fftq[$];
  logic [511:0] outq[$];
  int           mcyc;

  always @(posedge clk or negedge reset) begin
    logic [511:0] tmp;
    if (!reset) begin
      rdq_addr.delete(); rdq_due.delete(); wrq_due.delete(); fftq.delete(); outq.delete();
      mcyc = 0;
      rd_rsp_valid <= 1'b0; rd_rsp_data <= '0; wr_rsp_valid <= 1'b0;
      output_fifo_dout <= '0; output_fifo_empty <= 1'b1; output_fifo_almost_empty <= 1'b1;
      input_fifo_count <= '0; input_fifo_almost_full <= 1'b0;
    end else begin
      mcyc++;
      if (rd_req_valid) begin rdq_addr.push_back(rd_req_addr); rdq_due.push_back(mcyc + 3); end
      rd_rsp_valid <= 1'b0;
      if (rdq_addr.size() > 0 && rdq_due[0] <= mcyc) begin
        rd_rsp_valid <= 1'b1;
        rd_rsp_data  <= mk(rdq_addr.pop_front());
        void'(rdq_due.pop_front());
      end
      if (output_fifo_re && outq.size() > 0) begin tmp = outq.pop_front(); output_fifo_dout <= tmp; end
      if (input_fifo_we) fftq.push_back(input_fifo_din);
      if (!fft_stall && fftq.size() > 0) begin tmp = fftq.pop_front(); outq.push_back(~tmp); end
      output_fifo_empty        <= (outq.size() == 0);
      output_fifo_almost_empty <= (outq.size() <= 1);
      input_fifo_count         <= 3'(fftq.size());
      input_fifo_almost_full   <= (fftq.size() >= 7);
      if (wr_req_valid) wrq_due.push_back(mcyc + 2);
      wr_rsp_valid <= 1'b0;
      if (wrq_due.size() > 0 && wrq_due[0] <= mcyc) begin wr_rsp_valid <= 1'b1; void'(wrq_due.pop_front()); end
    end
  end

  int errors = 0, checks = 0;
  int n = 0;
  int start_n, done_rise_n, last_rsp_n, rsp_cnt, rdaf_viol, wraf_viol, max_infl;
  logic prev_done = 1'b0, busy_ever;
  logic s_busy, s_done, s_rdv, s_wrv, s_we, s_re, t_done;
  logic [31:0]  rd_log[$], wa_log[$];
  logic [511:0] wd_log[$];
  int           rd_n[$], wr_n[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    n++;
    s_busy = busy; s_done = done; s_rdv = rd_req_valid; s_wrv = wr_req_valid;
    s_we = input_fifo_we; s_re = output_fifo_re;
    if (busy) busy_ever = 1'b1;
    if (rd_req_valid) begin rd_log.push_back(rd_req_addr); rd_n.push_back(n); end
    if (wr_req_valid) begin wa_log.push_back(wr_req_addr); wd_log.push_back(wr_req_data); wr_n.push_back(n); end
    if (wr_rsp_valid) begin rsp_cnt++; last_rsp_n = n; end
    if (done && !prev_done) done_rise_n = n;
    prev_done = done;
    if (rd_req_valid && rd_req_almostfull) rdaf_viol++;
    if (output_fifo_re && wr_req_almostfull) wraf_viol++;
    if (rd_log.size() - wa_log.size() > max_infl) max_infl = rd_log.size() - wa_log.size();
  endtask

  // One clock cycle: sample mid-cycle, return just after the next active edge.
  task automatic cycle_();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); wa_log.delete(); wd_log.delete(); rd_n.delete(); wr_n.delete();
    done_rise_n = -1; last_rsp_n = -1; rsp_cnt = 0; rdaf_viol = 0; wraf_viol = 0;
    max_infl = 0; busy_ever = 1'b0;
  endtask

  // Pulse start in cycle t, and also sample cycle t+1.
  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] len);
    clear_logs();
    src_addr = s; dst_addr = d; ctx_length = len; start = 1'b1;
    cycle_();
    start_n = n; t_done = s_done;
    start = 1'b0;
    cycle_();
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (!s_done && k < bound) begin cycle_(); k++; end
    chk1({tag, "_done"}, s_done, 1'b1);
  endtask

  task automatic check_sb(input string tag, input logic [31:0] s, input logic [31:0] d, input int len);
    int bad = 0;
    chk32({tag, "_nrd"}, rd_log.size(), len);
    chk32({tag, "_nwr"}, wa_log.size(), len);
    chk32({tag, "_nrsp"}, rsp_cnt, len);
    for (int i = 0; i < len; i++) begin
      if (i >= rd_log.size() || rd_log[i] !== s + 32'(i)) bad++;
      if (i >= wa_log.size() || wa_log[i] !== d + 32'(i) || wd_log[i] !== ~mk(s + 32'(i))) bad++;
    end
    chk32({tag, "_sb"}, bad, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; ctx_length = '0;
    rd_req_almostfull = 1'b0; wr_req_almostfull = 1'b0; fft_stall = 1'b0;
    #1;
    clear_logs();

    // Reset state.
    cycle_(); cycle_();
    chk1("rst_busy", s_busy, 1'b0);
    chk1("rst_done", s_done, 1'b0);
    chk1("rst_rdv", s_rdv, 1'b0);
    chk1("rst_wrv", s_wrv, 1'b0);
    chk1("rst_we", s_we, 1'b0);
    chk1("rst_re", s_re, 1'b0);
    reset = 1'b1;
    cycle_();

    // Zero length: done at t+1, nothing issued, busy never rises.
    start_job(32'h0, 32'h0, 32'd0);
    chk1("zl_done_t", t_done, 1'b0);
    chk1("zl_done_t1", s_done, 1'b1);
    repeat (4) cycle_();
    chk1("zl_busy_ever", busy_ever, 1'b0);
    chk32("zl_nrd", rd_log.size(), 0);
    chk32("zl_nwr", wa_log.size(), 0);

    // Basic 4-line job restarted from DONE.
    start_job(32'h100, 32'h200, 32'd4);
    chk1("basic_busy_t1", s_busy, 1'b1);
    chk1("basic_done_t1", s_done, 1'b0);
    chk32("basic_first_rd", (rd_n.size() > 0) ? rd_n[0] : -1, start_n + 1);
    wait_done("basic", 200);
    for (int i = 0; i < 4; i++) begin
      chk32($sformatf("basic_rd%0d", i), (i < rd_log.size()) ? rd_log[i] : 32'hx, 32'h100 + 32'(i));
      chk32($sformatf("basic_wr%0d", i), (i < wa_log.size()) ? wa_log[i] : 32'hx, 32'h200 + 32'(i));
    end
    check_sb("basic", 32'h100, 32'h200, 4);
    chk32("basic_done_lat", done_rise_n, last_rsp_n + 1);

    // Inflight limit with the FFT stalled.
    fft_stall = 1'b1;
    start_job(32'h1000, 32'h2000, 32'd32);
    repeat (40) cycle_();
    chk32("infl_nrd", rd_log.size(), 7);
    chk32("infl_nwr", wa_log.size(), 0);
    fft_stall = 1'b0;
    wait_done("infl", 800);
    chk32("infl_max", max_infl, 7);
    chk32("infl_8th_rd", (rd_n.size() > 7 && wr_n.size() > 0) ? rd_n[7] : -1,
          (wr_n.size() > 0) ? wr_n[0] + 1 : -2);
    check_sb("infl", 32'h1000, 32'h2000, 32);

    // Read backpressure during cycles 3..10 after start.
    start_job(32'h3000, 32'h3800, 32'd16);
    for (int r = 2; r < 400 && !s_done; r++) begin
      rd_req_almostfull = (r >= 3 && r <= 10);
      cycle_();
    end
    rd_req_almostfull = 1'b0;
    chk1("rbp_done", s_done, 1'b1);
    chk32("rbp_viol", rdaf_viol, 0);
    chk32("rbp_first_rd", (rd_n.size() > 0) ? rd_n[0] : -1, start_n + 1);
    check_sb("rbp", 32'h3000, 32'h3800, 16);

    // Write backpressure pulse of 5 cycles mid-job.
    start_job(32'h4000, 32'h4800, 32'd16);
    for (int r = 2; r < 400 && !s_done; r++) begin
      wr_req_almostfull = (r >= 8 && r <= 12);
      cycle_();
    end
    wr_req_almostfull = 1'b0;
    chk1("wbp_done", s_done, 1'b1);
    chk32("wbp_viol", wraf_viol, 0);
    check_sb("wbp", 32'h4000, 32'h4800, 16);

    // Mid-job reset at line 5 of 10, then a fresh 3-line job.
    start_job(32'h5000, 32'h5800, 32'd10);
    for (int k = 0; k < 100 && rd_log.size() < 5; k++) cycle_();
    chk32("mid_nrd", rd_log.size(), 5);
    reset = 1'b0;
    #1;
    chk1("mid_rdv", rd_req_valid, 1'b0);
    chk1("mid_wrv", wr_req_valid, 1'b0);
    chk1("mid_we", input_fifo_we, 1'b0);
    chk1("mid_re", output_fifo_re, 1'b0);
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_done", done, 1'b0);
    chk32("mid_rdaddr", rd_req_addr, 32'h0);
    chk32("mid_wraddr", wr_req_addr, 32'h0);
    chk1("mid_wrdata", |wr_req_data, 1'b0);
    chk1("mid_din", |input_fifo_din, 1'b0);
    cycle_(); cycle_();
    reset = 1'b1;
    cycle_();
    start_job(32'h6000, 32'h7000, 32'd3);
    chk1("rst2_busy_t1", s_busy, 1'b1);
    wait_done("rst2", 200);
    check_sb("rst2", 32'h6000, 32'h7000, 3);
    chk32("rst2_done_lat", done_rise_n, last_rsp_n + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
